// File: rtl/alu_seq_unit_if.sv
// Operand-issue and result-return handshake bundle for alu_seq_unit.
// The controller drives the master side; the ALU sits on the slave side.
interface alu_seq_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_1;
  logic [WIDTH-1:0] operand_2;
  logic [3:0]       operator;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Answer1;
  logic [WIDTH-1:0] Answer2;
  logic             error;

  modport master (
    output in_valid, operand_1, operand_2, operator, out_ready,
    input  in_ready, out_valid, Answer1, Answer2, error
  );

  modport slave (
    input  in_valid, operand_1, operand_2, operator, out_ready,
    output in_ready, out_valid, Answer1, Answer2, error
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Registered ALU with valid/ready handshake: single-cycle logic ops, iterative
// shift-add multiply and restoring divide (one bit per cycle), error flagging.
module alu_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_unit_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state, state_n;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] ans1_r, ans2_r;
  logic             err_r;

  logic             accept, iter_last;
  logic             goes_iter;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res1, res2;
  logic             res_err;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] hi_n, lo_n;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sum       = {1'b0, bus.operand_1} + {1'b0, bus.operand_2};
    res1      = '0;
    res2      = '0;
    res_err   = 1'b0;
    goes_iter = 1'b0;
    case (bus.operator)
      OP_ADD: begin
        res1 = sum[WIDTH-1:0];
        res2 = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
      end
      OP_SUB: begin
        res1 = bus.operand_1 - bus.operand_2;
        res2 = {{(WIDTH-1){1'b0}}, (bus.operand_1 < bus.operand_2)};
      end
      OP_MUL: goes_iter = 1'b1;
      OP_DIV: begin
        if (bus.operand_2 == '0) begin
          res1    = '1;
          res2    = bus.operand_1;
          res_err = 1'b1;
        end else begin
          goes_iter = 1'b1;
        end
      end
      OP_AND:  res1 = bus.operand_1 & bus.operand_2;
      OP_OR:   res1 = bus.operand_1 | bus.operand_2;
      OP_XOR:  res1 = bus.operand_1 ^ bus.operand_2;
      default: res_err = 1'b1;
    endcase
  end

  // Multiply keeps {hi, lo} as partial product over the remaining multiplier;
  // divide keeps hi as remainder and shifts quotient bits into lo.
  always_comb begin
    mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    div_shift = {hi_r, lo_r[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_r});
    if (op_r == OP_MUL) begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_r[WIDTH-1:1]};
    end else begin
      hi_n = div_ge ? WIDTH'(div_shift - {1'b0, b_r}) : div_shift[WIDTH-1:0];
      lo_n = {lo_r[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_n       = state;
    accept        = 1'b0;
    iter_last     = 1'b0;
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_n = goes_iter ? ITER : DONE;
        end
      end
      ITER: begin
        if (cnt_r == CNT_LAST) begin
          iter_last = 1'b1;
          state_n   = DONE;
        end
      end
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // NOTE: reset is synchronous and clears the whole datapath, so an aborted
  // iteration can never leak a partial result after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      cnt_r  <= '0;
      ans1_r <= '0;
      ans2_r <= '0;
      err_r  <= 1'b0;
    end else if (accept) begin
      op_r  <= bus.operator;
      a_r   <= bus.operand_1;
      b_r   <= bus.operand_2;
      hi_r  <= '0;
      lo_r  <= (bus.operator == OP_MUL) ? bus.operand_2 : bus.operand_1;
      cnt_r <= '0;
      if (!goes_iter) begin
        ans1_r <= res1;
        ans2_r <= res2;
        err_r  <= res_err;
      end
    end else if (state == ITER) begin
      hi_r  <= hi_n;
      lo_r  <= lo_n;
      cnt_r <= cnt_r + 1'b1;
      if (iter_last) begin
        ans1_r <= lo_n;
        ans2_r <= hi_n;
        err_r  <= 1'b0;
      end
    end
  end

  assign bus.Answer1 = ans1_r;
  assign bus.Answer2 = ans2_r;
  assign bus.error   = err_r;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed, table-driven bench for alu_seq_unit at WIDTH=8, plus hand-written
// backpressure and mid-iteration reset sequences.
module tb_alu_seq_unit;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_seq_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_seq_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       ee;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Present one operation at a negedge and count cycles until out_valid.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       output int lat);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_issue", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.operand_1 = a;
    bus.operand_2 = b;
    bus.operator  = op;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handoff(input string name);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, "_out_valid_after"}, {31'd0, bus.out_valid}, 32'd0);
    check({name, "_in_ready_after"},  {31'd0, bus.in_ready},  32'd1);
  endtask

  vec_t vecs[$];
  int   lat;

  initial begin
    vecs.push_back('{"add_carry",  4'd0, 8'd200, 8'd100, 8'h2C, 8'd1,   1'b0, 1});
    vecs.push_back('{"sub_borrow", 4'd1, 8'd5,   8'd6,   8'hFF, 8'd1,   1'b0, 1});
    vecs.push_back('{"mul_small",  4'd2, 8'd6,   8'd5,   8'd30, 8'd0,   1'b0, 9});
    vecs.push_back('{"mul_max",    4'd2, 8'd255, 8'd255, 8'h01, 8'hFE, 1'b0, 9});
    vecs.push_back('{"div_200_7",  4'd3, 8'd200, 8'd7,   8'd28, 8'd4,   1'b0, 9});
    vecs.push_back('{"div_zero",   4'd3, 8'd5,   8'd0,   8'hFF, 8'd5,   1'b1, 1});
    vecs.push_back('{"add_zero",   4'd0, 8'd0,   8'd0,   8'h00, 8'd0,   1'b0, 1});
    vecs.push_back('{"sub_plain",  4'd1, 8'd6,   8'd5,   8'h01, 8'd0,   1'b0, 1});
    vecs.push_back('{"and",        4'd4, 8'hF0,  8'h3C,  8'h30, 8'd0,   1'b0, 1});
    vecs.push_back('{"or",         4'd5, 8'hF0,  8'h3C,  8'hFC, 8'd0,   1'b0, 1});
    vecs.push_back('{"div_small",  4'd3, 8'd7,   8'd200, 8'd0,  8'd7,   1'b0, 9});
    vecs.push_back('{"div_by_one", 4'd3, 8'd255, 8'd1,   8'hFF, 8'd0,   1'b0, 9});
    vecs.push_back('{"op_15",      4'd15, 8'd3,  8'd4,   8'd0,  8'd0,   1'b1, 1});
    vecs.push_back('{"mul_zero",   4'd2, 8'd0,   8'd255, 8'd0,  8'd0,   1'b0, 9});

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    bus.operator  = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_Answer1",   {24'd0, bus.Answer1},     32'd0);
    check("rst_Answer2",   {24'd0, bus.Answer2},     32'd0);
    check("rst_error",     {31'd0, bus.error},       32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid},   32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready},    32'd1);

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].op, lat);
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      check({vecs[i].name, "_Answer1"}, {24'd0, bus.Answer1}, {24'd0, vecs[i].e1});
      check({vecs[i].name, "_Answer2"}, {24'd0, bus.Answer2}, {24'd0, vecs[i].e2});
      check({vecs[i].name, "_error"},   {31'd0, bus.error},   {31'd0, vecs[i].ee});
      handoff(vecs[i].name);
    end

    // Backpressure: result held, new operands ignored while out_ready is low
    issue(8'hF0, 8'h3C, 4'd6, lat);
    check("bp_latency", lat, 1);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid  = 1'b1;
      bus.operand_1 = 8'd1;
      bus.operand_2 = 8'd1;
      bus.operator  = 4'd0;
      @(negedge clk);
      check("bp_Answer1_hold", {24'd0, bus.Answer1},   32'h0000_00CC);
      check("bp_Answer2_hold", {24'd0, bus.Answer2},   32'd0);
      check("bp_in_ready_low", {31'd0, bus.in_ready},  32'd0);
      check("bp_out_valid",    {31'd0, bus.out_valid}, 32'd1);
    end
    bus.in_valid = 1'b0;
    handoff("bp");
    check("bp_Answer1_kept", {24'd0, bus.Answer1}, 32'h0000_00CC);
    @(negedge clk);
    check("bp_no_stray_result", {31'd0, bus.out_valid}, 32'd0);

    // Reset during the 4th ITER cycle of a multiply
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.operand_1 = 8'd255;
    bus.operand_2 = 8'd255;
    bus.operator  = 4'd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid_in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_Answer1",   {24'd0, bus.Answer1},   32'd0);
    check("mid_rst_Answer2",   {24'd0, bus.Answer2},   32'd0);
    check("mid_rst_error",     {31'd0, bus.error},     32'd0);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    begin
      logic seen;
      seen = 1'b0;
      repeat (12) begin
        @(negedge clk);
        seen = seen | bus.out_valid;
      end
      check("mid_rst_no_partial", {31'd0, seen}, 32'd0);
    end

    // Illegal operator after reset
    issue(8'd12, 8'd34, 4'd9, lat);
    check("op9_latency", lat, 1);
    check("op9_Answer1", {24'd0, bus.Answer1}, 32'd0);
    check("op9_Answer2", {24'd0, bus.Answer2}, 32'd0);
    check("op9_error",   {31'd0, bus.error},   32'd1);
    handoff("op9");

    // error clears on the next good result
    issue(8'd1, 8'd2, 4'd0, lat);
    check("clr_Answer1", {24'd0, bus.Answer1}, 32'd3);
    check("clr_error",   {31'd0, bus.error},   32'd0);
    handoff("clr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
